// File: rtl/laser_fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : laser_fir_pkg
// Purpose  : Shared types, defaults and output clamp for the laser FIR block.
// Revision : 1.0
// ============================================================================
package laser_fir_pkg;

    localparam int DEF_TAP_NUM   = 16;
    localparam int DEF_COEF_FRAC = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } loader_state_t;

    // Saturate a signed value into the unsigned range [0, 2^width-1].
    function automatic logic [63:0] clamp_unsigned(input logic signed [63:0] value,
                                                   input int unsigned        width);
        logic signed [63:0] max_val;
        max_val = (64'sd1 <<< width) - 64'sd1;
        if (value < 64'sd0) begin
            return 64'd0;
        end
        if (value > max_val) begin
            return max_val;
        end
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_tap_loader.sv
`default_nettype none
// ============================================================================
// Module   : fir_tap_loader
// Purpose  : Fetches a tap set over the read handshake into a shadow bank and
//            swaps it into the active bank once the whole set has arrived.
// Revision : 1.0
// ============================================================================
module fir_tap_loader
    import laser_fir_pkg::*;
#(
    parameter int FIR_TAP_WIDTH = 32,
    parameter int TAP_NUM       = DEF_TAP_NUM,
    parameter int COEF_FRAC     = DEF_COEF_FRAC
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  tap_ready_i,
    input  logic                                  upmode_i,
    input  logic                                  start_rise_i,
    input  logic                                  tap_vld_i,
    input  logic [FIR_TAP_WIDTH-1:0]              tap_data_i,
    output logic                                  tap_ren_o,
    output logic [TAP_NUM-1:0][FIR_TAP_WIDTH-1:0] taps_o
);

    localparam int c_CNT_W = $clog2(TAP_NUM + 1);
    localparam int c_IDX_W = $clog2(TAP_NUM);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TAP_NUM - 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(TAP_NUM);
    localparam logic [TAP_NUM-1:0][FIR_TAP_WIDTH-1:0] c_IMPULSE =
        {{((TAP_NUM - 1) * FIR_TAP_WIDTH){1'b0}}, FIR_TAP_WIDTH'(1) << COEF_FRAC};

    loader_state_t                         r_state;
    logic [c_CNT_W-1:0]                    r_req_cnt;
    logic [c_CNT_W-1:0]                    r_word_cnt;
    logic                                  r_loaded;
    logic [TAP_NUM-1:0][FIR_TAP_WIDTH-1:0] r_shadow;
    logic                                  w_trigger;

    assign w_trigger = tap_ready_i && (r_state == ST_IDLE) &&
                       (!r_loaded || (upmode_i && start_rise_i));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            tap_ren_o  <= 1'b0;
            r_req_cnt  <= '0;
            r_word_cnt <= '0;
            r_loaded   <= 1'b0;
            r_shadow   <= '0;
            taps_o     <= c_IMPULSE;
        end else begin
            // Words may already arrive while requests are still going out.
            if ((r_state != ST_IDLE) && tap_vld_i && (r_word_cnt != c_FULL)) begin
                r_shadow[r_word_cnt[c_IDX_W-1:0]] <= tap_data_i;
                r_word_cnt <= r_word_cnt + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_state    <= ST_REQ;
                        tap_ren_o  <= 1'b1;
                        r_req_cnt  <= '0;
                        r_word_cnt <= '0;
                    end
                end
                ST_REQ: begin
                    r_req_cnt <= r_req_cnt + 1'b1;
                    if (r_req_cnt == c_LAST) begin
                        tap_ren_o <= 1'b0;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_word_cnt == c_FULL) begin
                        taps_o   <= r_shadow;
                        r_loaded <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    tap_ren_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/laser_fir_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : laser_fir_ctrl
// Purpose  : Three-stage run-time-loadable FIR with bypass and aligned flags.
// Revision : 1.0
// ============================================================================
module laser_fir_ctrl
    import laser_fir_pkg::*;
#(
    parameter int FIR_TAP_WIDTH = 32,
    parameter int DATA_WIDTH    = 16,
    parameter int TAP_NUM       = DEF_TAP_NUM,
    parameter int COEF_FRAC     = DEF_COEF_FRAC
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     laser_fir_upmode_i,
    input  logic                     laser_fir_en_i,
    input  logic                     laser_start_i,
    output logic                     fir_tap_para_ren_o,
    input  logic                     fir_tap_para_vld_i,
    input  logic [FIR_TAP_WIDTH-1:0] fir_tap_para_data_i,
    input  logic                     fir_tap_ready_i,
    input  logic                     encode_zero_flag_i,
    input  logic                     lp_recover_acc_flag_i,
    input  logic                     laser_vld_i,
    input  logic [DATA_WIDTH-1:0]    laser_data_i,
    output logic                     fir_zero_flag_o,
    output logic                     fir_acc_flag_o,
    output logic                     fir_laser_vld_o,
    output logic [DATA_WIDTH-1:0]    fir_laser_data_o
);

    localparam int c_PROD_W = FIR_TAP_WIDTH + DATA_WIDTH + 1;
    localparam int c_ACC_W  = c_PROD_W + $clog2(TAP_NUM);

    logic [TAP_NUM-1:0][FIR_TAP_WIDTH-1:0] w_taps;
    logic [DATA_WIDTH-1:0]        r_hist      [TAP_NUM];
    logic [DATA_WIDTH-1:0]        w_hist_next [TAP_NUM];
    logic signed [c_PROD_W-1:0]   r_prod      [TAP_NUM];
    logic signed [c_ACC_W-1:0]    w_sum;
    logic signed [c_ACC_W-1:0]    r_acc;
    logic signed [c_ACC_W-1:0]    w_scaled;
    logic                         r_start_d;
    logic                         w_start_rise;
    logic                         r_vld1, r_vld2, r_en1, r_en2;
    logic [DATA_WIDTH-1:0]        r_byp1, r_byp2;
    logic [1:0]                   r_zero_d, r_accf_d;

    assign w_start_rise = laser_start_i && !r_start_d;
    assign w_scaled     = r_acc >>> COEF_FRAC;

    fir_tap_loader #(
        .FIR_TAP_WIDTH (FIR_TAP_WIDTH),
        .TAP_NUM       (TAP_NUM),
        .COEF_FRAC     (COEF_FRAC)
    ) u_tap_loader (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .tap_ready_i  (fir_tap_ready_i),
        .upmode_i     (laser_fir_upmode_i),
        .start_rise_i (w_start_rise),
        .tap_vld_i    (fir_tap_para_vld_i),
        .tap_data_i   (fir_tap_para_data_i),
        .tap_ren_o    (fir_tap_para_ren_o),
        .taps_o       (w_taps)
    );

    // A start edge wipes the history before the coincident sample is shifted in.
    always_comb begin
        for (int k = 0; k < TAP_NUM; k++) begin
            w_hist_next[k] = w_start_rise ? '0 : r_hist[k];
        end
        if (laser_vld_i) begin
            for (int k = TAP_NUM - 1; k > 0; k--) begin
                w_hist_next[k] = w_start_rise ? '0 : r_hist[k-1];
            end
            w_hist_next[0] = laser_data_i;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < TAP_NUM; k++) begin
            w_sum = w_sum + c_ACC_W'(r_prod[k]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_start_d        <= 1'b0;
            for (int k = 0; k < TAP_NUM; k++) begin
                r_hist[k] <= '0;
                r_prod[k] <= '0;
            end
            r_acc            <= '0;
            r_vld1           <= 1'b0;
            r_vld2           <= 1'b0;
            r_en1            <= 1'b0;
            r_en2            <= 1'b0;
            r_byp1           <= '0;
            r_byp2           <= '0;
            r_zero_d         <= '0;
            r_accf_d         <= '0;
            fir_zero_flag_o  <= 1'b0;
            fir_acc_flag_o   <= 1'b0;
            fir_laser_vld_o  <= 1'b0;
            fir_laser_data_o <= '0;
        end else begin
            r_start_d <= laser_start_i;
            r_hist    <= w_hist_next;
            for (int k = 0; k < TAP_NUM; k++) begin
                r_prod[k] <= $signed({{(c_PROD_W-FIR_TAP_WIDTH){w_taps[k][FIR_TAP_WIDTH-1]}}, w_taps[k]}) *
                             $signed({{(c_PROD_W-DATA_WIDTH){1'b0}}, w_hist_next[k]});
            end
            r_vld1 <= laser_vld_i;
            r_en1  <= laser_fir_en_i;
            r_byp1 <= laser_data_i;

            r_acc  <= w_sum;
            r_vld2 <= r_vld1;
            r_en2  <= r_en1;
            r_byp2 <= r_byp1;

            fir_laser_vld_o  <= r_vld2;
            fir_laser_data_o <= r_en2 ? DATA_WIDTH'(clamp_unsigned(64'(w_scaled), DATA_WIDTH))
                                      : r_byp2;

            r_zero_d        <= {r_zero_d[0], encode_zero_flag_i};
            r_accf_d        <= {r_accf_d[0], lp_recover_acc_flag_i};
            fir_zero_flag_o <= r_zero_d[1];
            fir_acc_flag_o  <= r_accf_d[1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_laser_fir_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_laser_fir_ctrl
// Purpose  : Scoreboard bench for laser_fir_ctrl against a queue-based FIR model.
// Revision : 1.0
// ============================================================================
module tb_laser_fir_ctrl;

    localparam int TW = 32;
    localparam int DW = 16;
    localparam int NT = 16;
    localparam int CF = 16;
    localparam longint MAXV = (64'sd1 <<< DW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          laser_fir_upmode_i = 1'b0;
    logic          laser_fir_en_i = 1'b0;
    logic          laser_start_i = 1'b0;
    logic          fir_tap_para_ren_o;
    logic          fir_tap_para_vld_i = 1'b0;
    logic [TW-1:0] fir_tap_para_data_i = '0;
    logic          fir_tap_ready_i = 1'b0;
    logic          encode_zero_flag_i = 1'b0;
    logic          lp_recover_acc_flag_i = 1'b0;
    logic          laser_vld_i = 1'b0;
    logic [DW-1:0] laser_data_i = '0;
    logic          fir_zero_flag_o, fir_acc_flag_o, fir_laser_vld_o;
    logic [DW-1:0] fir_laser_data_o;

    laser_fir_ctrl #(.FIR_TAP_WIDTH(TW), .DATA_WIDTH(DW), .TAP_NUM(NT), .COEF_FRAC(CF)) dut (
        .clk_i                 (clk_i),
        .rst_n_i               (rst_n_i),
        .laser_fir_upmode_i    (laser_fir_upmode_i),
        .laser_fir_en_i        (laser_fir_en_i),
        .laser_start_i         (laser_start_i),
        .fir_tap_para_ren_o    (fir_tap_para_ren_o),
        .fir_tap_para_vld_i    (fir_tap_para_vld_i),
        .fir_tap_para_data_i   (fir_tap_para_data_i),
        .fir_tap_ready_i       (fir_tap_ready_i),
        .encode_zero_flag_i    (encode_zero_flag_i),
        .lp_recover_acc_flag_i (lp_recover_acc_flag_i),
        .laser_vld_i           (laser_vld_i),
        .laser_data_i          (laser_data_i),
        .fir_zero_flag_o       (fir_zero_flag_o),
        .fir_acc_flag_o        (fir_acc_flag_o),
        .fir_laser_vld_o       (fir_laser_vld_o),
        .fir_laser_data_o      (fir_laser_data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [DW-1:0] data; int due; } exp_t;
    typedef struct { bit zf; bit af; int due; } flg_t;

    exp_t    exp_q[$];
    flg_t    flg_q[$];
    exp_t    mon_e;
    flg_t    mon_f;
    int      total = 0;
    int      bad = 0;
    int      cyc_n = 0;
    bit      mon_en = 1'b0;
    logic [TW-1:0] mem [NT];
    longint  m_taps [NT];
    longint  m_hist[$];
    bit      m_prev_start;
    bit      d_start, d_en, d_zf, d_af;
    int      rsp_idx = 0;
    bit      rsp_pend = 1'b0;

    always @(posedge clk_i) cyc_n++;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    // Tap memory: answers each read request one cycle later, words in order.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            rsp_pend = 1'b0;
            rsp_idx = 0;
            fir_tap_para_vld_i = 1'b0;
        end else begin
            fir_tap_para_vld_i = rsp_pend;
            fir_tap_para_data_i = rsp_pend ? mem[rsp_idx] : '0;
            if (rsp_pend) rsp_idx = (rsp_idx + 1) % NT;
            rsp_pend = fir_tap_para_ren_o;
        end
    end

    always @(negedge clk_i) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].due < cyc_n) begin
                mon_e = exp_q.pop_front();
                chk("missing_output_due", cyc_n, mon_e.due);
            end
            if (fir_laser_vld_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output_vld", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("output_latency", cyc_n, mon_e.due);
                    chk("output_data", fir_laser_data_o, mon_e.data);
                end
            end
            if (flg_q.size() > 0 && flg_q[0].due == cyc_n) begin
                mon_f = flg_q.pop_front();
                chk("zero_flag", fir_zero_flag_o, mon_f.zf);
                chk("acc_flag", fir_acc_flag_o, mon_f.af);
            end
        end
    end

    task automatic model_reset();
        foreach (m_taps[k]) m_taps[k] = 0;
        m_taps[0] = 64'sd1 <<< CF;
        m_hist.delete();
        m_prev_start = 1'b0;
    endtask

    // One cycle of stimulus; the expected response is pushed from the model.
    task automatic step(input bit v, input logic [DW-1:0] x);
        longint acc;
        longint y;
        exp_t   e;
        flg_t   f;
        @(negedge clk_i);
        laser_vld_i = v;
        laser_data_i = x;
        laser_start_i = d_start;
        laser_fir_en_i = d_en;
        encode_zero_flag_i = d_zf;
        lp_recover_acc_flag_i = d_af;
        if (d_start && !m_prev_start) m_hist.delete();
        m_prev_start = d_start;
        f.zf = d_zf;
        f.af = d_af;
        f.due = cyc_n + 3;
        flg_q.push_back(f);
        if (v) begin
            m_hist.push_front(longint'(x));
            if (m_hist.size() > NT) void'(m_hist.pop_back());
            acc = 0;
            foreach (m_hist[k]) acc += m_taps[k] * m_hist[k];
            acc = acc >>> CF;
            y = (acc < 0) ? 0 : ((acc > MAXV) ? MAXV : acc);
            if (!d_en) y = longint'(x);
            e.data = DW'(y);
            e.due = cyc_n + 3;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    task automatic apply_reset(input int ncyc, input bit ready_after);
        @(negedge clk_i);
        mon_en = 1'b0;
        rst_n_i = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk_i);
            laser_vld_i = 1'b1;
            laser_data_i = DW'($urandom);
            encode_zero_flag_i = 1'b1;
            lp_recover_acc_flag_i = 1'b1;
            laser_start_i = i[0];
            laser_fir_en_i = 1'b1;
            chk("reset_vld", fir_laser_vld_o, 0);
            chk("reset_data", fir_laser_data_o, 0);
            chk("reset_zero_flag", fir_zero_flag_o, 0);
            chk("reset_acc_flag", fir_acc_flag_o, 0);
            chk("reset_ren", fir_tap_para_ren_o, 0);
        end
        @(negedge clk_i);
        exp_q.delete();
        flg_q.delete();
        model_reset();
        laser_vld_i = 1'b0;
        laser_data_i = '0;
        encode_zero_flag_i = 1'b0;
        lp_recover_acc_flag_i = 1'b0;
        laser_start_i = 1'b0;
        laser_fir_upmode_i = 1'b0;
        d_start = 1'b0;
        d_zf = 1'b0;
        d_af = 1'b0;
        fir_tap_ready_i = ready_after;
        rst_n_i = 1'b1;
        mon_en = 1'b1;
    endtask

    // Loads mem[] either as the first set since reset or via an upmode start edge.
    task automatic do_load(input bit via_start);
        int n;
        n = 0;
        fir_tap_ready_i = 1'b1;
        if (via_start) begin
            laser_fir_upmode_i = 1'b1;
            d_start = 1'b0;
            step(1'b0, '0);
            d_start = 1'b1;
        end
        step(1'b0, '0);
        for (int i = 0; i < 8 && !fir_tap_para_ren_o; i++) step(1'b0, '0);
        while (fir_tap_para_ren_o && n < 40) begin
            n++;
            step(1'b0, '0);
        end
        chk("load_ren_cycles", n, NT);
        idle(4);
        laser_fir_upmode_i = 1'b0;
        foreach (m_taps[k]) m_taps[k] = longint'($signed(mem[k]));
    endtask

    initial begin
        int n;
        d_en = 1'b1;
        foreach (mem[k]) mem[k] = '0;
        model_reset();
        apply_reset(5, 1'b0);

        // Impulse taps out of reset.
        step(1'b1, 16'd100);
        step(1'b1, 16'hFFFF);
        step(1'b1, 16'd7);
        idle(4);

        // Bypass with a flag pulse.
        d_en = 1'b0;
        step(1'b1, 16'd1);
        step(1'b1, 16'd2);
        step(1'b1, 16'd3);
        idle(1);
        d_zf = 1'b1;
        d_af = 1'b1;
        step(1'b0, '0);
        d_zf = 1'b0;
        step(1'b0, '0);
        d_af = 1'b0;
        idle(4);
        d_en = 1'b1;

        // Ramp taps, impulse response with a coincident start edge.
        foreach (mem[k]) mem[k] = TW'(k + 1) << CF;
        do_load(1'b0);
        d_start = 1'b1;
        step(1'b1, 16'd1);
        for (int i = 0; i < 17; i++) step(1'b1, 16'd0);
        idle(4);

        // Start edge without upmode must not request taps.
        foreach (mem[k]) mem[k] = '0;
        d_start = 1'b0;
        step(1'b0, '0);
        d_start = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, '0);
            if (fir_tap_para_ren_o) n++;
        end
        chk("no_reload_ren", n, 0);
        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom_range(1, 9000)));

        // Upmode reload of an all-zero set.
        do_load(1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom_range(1, 65535)));
        idle(4);

        // Saturation high and low.
        foreach (mem[k]) mem[k] = TW'(2) << CF;
        do_load(1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 16'hFFFF);
        idle(4);
        foreach (mem[k]) mem[k] = '0;
        mem[0] = TW'(-(64'sd1 <<< CF));
        do_load(1'b1);
        step(1'b1, 16'd500);
        step(1'b1, 16'd1);
        idle(4);

        // Random taps and a random stream with gaps, bypass, flags and start edges.
        foreach (mem[k]) mem[k] = ($urandom_range(0, 3) == 0) ? TW'($urandom)
                                  : TW'($urandom_range(0, 1 << 18)) - TW'(1 << 17);
        do_load(1'b1);
        for (int i = 0; i < 400; i++) begin
            d_en = ($urandom_range(0, 3) != 0);
            d_zf = $urandom_range(0, 1) == 1;
            d_af = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 19) == 0) d_start = !d_start;
            step($urandom_range(0, 3) != 0, DW'($urandom));
        end
        d_en = 1'b1;
        d_zf = 1'b0;
        d_af = 1'b0;

        // Explicit history clear after nonzero samples.
        d_start = 1'b0;
        step(1'b1, 16'd4000);
        d_start = 1'b1;
        step(1'b1, 16'd1234);
        step(1'b1, 16'd99);
        idle(6);

        // Reset in the middle of a load returns to impulse taps.
        foreach (mem[k]) mem[k] = TW'($urandom);
        laser_fir_upmode_i = 1'b1;
        d_start = 1'b0;
        step(1'b0, '0);
        d_start = 1'b1;
        step(1'b0, '0);
        for (int i = 0; i < 8 && !fir_tap_para_ren_o; i++) step(1'b0, '0);
        chk("midload_ren_seen", fir_tap_para_ren_o, 1);
        idle(5);
        apply_reset(3, 1'b0);
        step(1'b1, 16'd100);
        step(1'b1, 16'd300);
        idle(4);

        // After reset the first ready triggers a load again.
        foreach (mem[k]) mem[k] = TW'(NT - k) << CF;
        do_load(1'b0);
        d_start = 1'b0;
        step(1'b0, '0);
        d_start = 1'b1;
        step(1'b1, 16'd3);
        for (int i = 0; i < 4; i++) step(1'b1, 16'd0);
        idle(6);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
